// File: rtl/ternary_mm_pkg.sv
// Shared definitions for the ternary MAC array: weight codes, weight decode
// and the readout FSM state type.
package ternary_mm_pkg;

    localparam logic [1:0] W_ZERO = 2'b00;
    localparam logic [1:0] W_POS  = 2'b01;
    localparam logic [1:0] W_NEG  = 2'b10;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // 2'b11 is treated as a second encoding of -1.
    function automatic logic signed [1:0] w_decode(input logic [1:0] w);
        case (w)
            W_POS:        return 2'sd1;
            W_NEG, 2'b11: return -2'sd1;
            default:      return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/ternary_mac_cell.sv
// One ternary accumulator: adds, subtracts or holds the activation when its
// column is enabled; clr zeroes it after the updated value is exposed.
module ternary_mac_cell
    import ternary_mm_pkg::*;
#(
    parameter int ACC_W = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       weight,
    input  logic [ACC_W-1:0] act,
    output logic [ACC_W-1:0] acc_upd
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic signed [1:0] wv;

    // acc_upd includes this cycle's beat so a same-cycle snapshot sees it.
    always_comb begin
        wv      = w_decode(weight);
        acc_upd = acc_q;
        if (en && wv == 2'sd1)       acc_upd = acc_q + act;
        else if (en && wv == -2'sd1) acc_upd = acc_q - act;
        acc_d = clr ? '0 : acc_upd;
    end

    always_ff @(posedge clk) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

endmodule

// File: rtl/ternary_mac_array.sv
// ROWS x COLS ternary MAC tile with snapshot-and-drain readout through a
// valid/ready port. Define TERNARY_RELU_EN to honour the relu input.
module ternary_mac_array
    import ternary_mm_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 2,
    parameter int IN_W  = 8,
    parameter int ACC_W = 17,
    parameter int OUT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [2*ROWS-1:0]        in_weights,
    input  logic [IN_W-1:0]          in_act,
    input  logic                     start_readout,
    input  logic [$clog2(ACC_W)-1:0] out_shift,
    input  logic                     relu,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     busy
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SH_W  = $clog2(ACC_W);
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic signed [CMP_W-1:0] SAT_MAX = CMP_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CMP_W-1:0] SAT_MIN = ~SAT_MAX;

    state_e                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [N-1:0][ACC_W-1:0] queue_q, queue_d;
    logic [SH_W-1:0]         shift_q, shift_d;
    logic                    relu_q, relu_d;

    logic signed [ACC_W-1:0] act_ext;
    logic [N-1:0][ACC_W-1:0] acc_upd;
    logic                    take;

    assign act_ext = ACC_W'($signed(in_act));
    assign take    = start_readout && (state_q == ACCUM);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            ternary_mac_cell #(.ACC_W(ACC_W)) u_cell (
                .clk     (clk),
                .reset   (reset),
                .en      (in_valid && (col_q == COL_W'(c))),
                .clr     (take),
                .weight  (in_weights[2*r +: 2]),
                .act     (act_ext),
                .acc_upd (acc_upd[r*COLS + c])
            );
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        idx_d   = idx_q;
        queue_d = queue_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        if (in_valid) col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
        case (state_q)
            ACCUM: begin
                if (take) begin
                    queue_d = acc_upd;
                    col_d   = '0;
                    idx_d   = '0;
                    shift_d = out_shift;
                    relu_d  = relu;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            col_q   <= '0;
            idx_q   <= '0;
            queue_q <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            idx_q   <= idx_d;
            queue_q <= queue_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
        end
    end

    logic signed [ACC_W-1:0] shifted;
    logic signed [CMP_W-1:0] wide;
    logic [OUT_W-1:0]        sat;

    // Saturation compares in a width that holds both ACC_W and OUT_W values.
    always_comb begin
        shifted = $signed(queue_q[idx_q]) >>> shift_q;
        wide    = CMP_W'(shifted);
        if (wide > SAT_MAX)      sat = OUT_W'(SAT_MAX);
        else if (wide < SAT_MIN) sat = OUT_W'(SAT_MIN);
        else                     sat = wide[OUT_W-1:0];
`ifdef TERNARY_RELU_EN
        if (relu_q && shifted < 0) sat = '0;
`endif
    end

`ifndef TERNARY_RELU_EN
    logic unused_relu;
    assign unused_relu = relu_q;
`endif

    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_data  = out_valid ? sat : '0;

endmodule

// File: tb/tb_ternary_mac_array.sv
// Scoreboard bench for ternary_mac_array: a tile model predicts every drained
// entry, a negedge monitor compares whatever the DUT presents.
module tb_ternary_mac_array;

    localparam int ROWS  = 4;
    localparam int COLS  = 2;
    localparam int IN_W  = 8;
    localparam int ACC_W = 17;
    localparam int OUT_W = 8;
    localparam int SH_W  = $clog2(ACC_W);
    localparam int WB    = 2 * ROWS;
`ifdef TERNARY_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WB-1:0]    in_weights;
    logic [IN_W-1:0]  in_act;
    logic             start_readout;
    logic [SH_W-1:0]  out_shift;
    logic             relu;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             busy;

    ternary_mac_array #(.ROWS(ROWS), .COLS(COLS), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_weights(in_weights), .in_act(in_act),
        .start_readout(start_readout), .out_shift(out_shift), .relu(relu), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    int     hs_cnt = 0;
    int     sb[$];
    longint acc_m[ROWS][COLS];
    int     col_m = 0;
    bit     force_rdy = 1'b1;
    bit     rand_rdy = 1'b0;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    function automatic int wval(input logic [1:0] w);
        if (w == 2'b00) return 0;
        if (w == 2'b01) return 1;
        return -1;
    endfunction

    function automatic logic [WB-1:0] all_w(input logic [1:0] c);
        logic [WB-1:0] v;
        for (int r = 0; r < ROWS; r++) v[2*r +: 2] = c;
        return v;
    endfunction

    // Two's-complement wrap to ACC_W, floor-divide by 2^sh, clamp, optional ReLU.
    function automatic int expect_of(input longint a, input int sh, input bit rl);
        longint m, v, d, q;
        m = 64'sd1 <<< ACC_W;
        v = a % m;
        if (v < 0) v += m;
        if (v >= m / 2) v -= m;
        d = 64'sd1 <<< sh;
        q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        if (RELU_ON && rl && q < 0) q = 0;
        return int'(q);
    endfunction

    task automatic clear_model();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) acc_m[r][c] = 0;
        col_m = 0;
    endtask

    // One clock: drive, let the edge happen, then advance the model.
    task automatic cyc(input bit v, input logic [WB-1:0] w, input int a,
                       input bit st, input int sh, input bit rl);
        bit acc_ok;
        in_valid = v; in_weights = w; in_act = IN_W'(a);
        start_readout = st; out_shift = SH_W'(sh); relu = rl;
        acc_ok = st && (sb.size() == 0);
        @(posedge clk);
        if (v) begin
            for (int r = 0; r < ROWS; r++) acc_m[r][col_m] += wval(w[2*r +: 2]) * a;
            col_m = (col_m + 1) % COLS;
        end
        if (acc_ok) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) sb.push_back(expect_of(acc_m[r][c], sh, rl));
            clear_model();
        end
        #1;
        in_valid = 1'b0; start_readout = 1'b0;
    endtask

    task automatic rnd_beat();
        cyc(($urandom % 4) != 0, WB'($urandom), int'($urandom_range(0, 255)) - 128, 1'b0, 0, 1'b0);
    endtask

    task automatic wait_idle(input bit beats);
        int i;
        for (i = 0; i < 400 && sb.size() != 0; i++) begin
            if (beats) rnd_beat();
            else cyc(1'b0, '0, 0, 1'b0, 0, 1'b0);
        end
        chk("drain_done_entries_left", sb.size(), 0);
        chk("busy_after_drain", busy, 0);
        sb.delete();
    endtask

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? (($urandom % 4) != 0) : force_rdy;
    end

    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL out_unexpected: got %0d, expected no output", $signed(out_data));
            end else begin
                chk("out_data", longint'($signed(out_data)), sb[0]);
                if (out_ready) begin
                    void'(sb.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_weights = '0; in_act = '0;
        start_readout = 1'b0; out_shift = '0; relu = 1'b0; out_ready = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;

        // Basic tile: 10 and -3 per row, valid the cycle after the snapshot.
        cyc(1'b1, all_w(2'b01), 10, 1'b0, 0, 1'b0);
        cyc(1'b1, all_w(2'b10), 3, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        chk("valid_after_start", out_valid, 1);
        wait_idle(1'b0);

        // Same-cycle beat lands in the snapshot; the next tile starts clean.
        cyc(1'b1, all_w(2'b01), 5, 1'b1, 0, 1'b0);
        wait_idle(1'b0);
        cyc(1'b1, all_w(2'b01), 1, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        wait_idle(1'b0);

        // 12700 per column: shift 4 saturates, shift 8 gives 49.
        for (int s = 0; s < 2; s++) begin
            repeat (200) cyc(1'b1, all_w(2'b01), 127, 1'b0, 0, 1'b0);
            cyc(1'b0, '0, 0, 1'b1, (s == 0) ? 4 : 8, 1'b0);
            wait_idle(1'b0);
        end

        // Accumulator wrap: 600 x (+128) per column overflows 17 bits.
        repeat (1200) cyc(1'b1, all_w(2'b11), -128, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 9, 1'b0);
        wait_idle(1'b0);

        // Backpressure hold and an ignored start_readout while draining.
        cyc(1'b1, all_w(2'b01), 9, 1'b0, 0, 1'b0);
        cyc(1'b1, all_w(2'b11), 4, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 2, 1'b0);
        force_rdy = 1'b0;
        cyc(1'b0, '0, 0, 1'b0, 0, 1'b0);
        cyc(1'b1, all_w(2'b01), 6, 1'b1, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b0, 0, 1'b0);
        force_rdy = 1'b1;
        wait_idle(1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        wait_idle(1'b0);

        // Reset while the third entry is on the port.
        cyc(1'b1, all_w(2'b01), 20, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        base = hs_cnt;
        for (int i = 0; i < 20 && hs_cnt < base + 2; i++) cyc(1'b1, all_w(2'b01), 3, 1'b0, 0, 1'b0);
        chk("reset_point_handshakes", hs_cnt - base, 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        clear_model();
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_out_data", out_data, 0);
        chk("midreset_busy", busy, 0);
        reset = 1'b0;
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        wait_idle(1'b0);
        cyc(1'b1, all_w(2'b01), 7, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b0);
        wait_idle(1'b0);

        // -40 with relu requested.
        cyc(1'b1, all_w(2'b10), 40, 1'b0, 0, 1'b0);
        cyc(1'b1, all_w(2'b00), 0, 1'b0, 0, 1'b0);
        cyc(1'b0, '0, 0, 1'b1, 0, 1'b1);
        wait_idle(1'b0);

        // Random tiles with random backpressure and beats during drain.
        rand_rdy = 1'b1;
        for (int t = 0; t < 25; t++) begin
            repeat ($urandom_range(1, 30)) rnd_beat();
            cyc(($urandom % 2) == 0, WB'($urandom), int'($urandom_range(0, 255)) - 128,
                1'b1, int'($urandom_range(0, 10)), ($urandom % 2) == 0);
            wait_idle(1'b1);
        end
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ternary_mac_array.md
TERNARY_MAC_ARRAY -- requirements
Module: ternary_mac_array

Interface
REQ-001 SHALL have parameter ROWS, default 4, meaning weight rows (one 2-bit ternary weight each).
REQ-002 SHALL have parameter COLS, default 2, meaning column slices time-multiplexed per row.
REQ-003 SHALL have parameter IN_W, default 8, meaning signed activation width.
REQ-004 SHALL have parameter ACC_W, default 17, meaning signed accumulator width.
REQ-005 SHALL have parameter OUT_W, default 8, meaning signed output width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1 bit: a weight/activation beat is present.
REQ-009 SHALL have port in_weights, input, 2*ROWS bits: packed ternary weights, row r in bits [2r+1:2r].
REQ-010 SHALL have port in_act, input, IN_W bits: signed activation shared by all rows.
REQ-011 SHALL have port start_readout, input, 1 bit: snapshot the tile and begin draining.
REQ-012 SHALL have port out_shift, input, $clog2(ACC_W) bits: arithmetic right shift, sampled on accepted start_readout.
REQ-013 SHALL have port relu, input, 1 bit: ReLU request, sampled with out_shift.
REQ-014 SHALL have port out_valid, output, 1 bit; out_ready, input, 1 bit; out_data, output, OUT_W bits.
REQ-015 SHALL have port busy, output, 1 bit: high while in DRAIN.

Function
REQ-016 SHALL decode weights as 00 -> 0, 01 -> +1, 10/11 -> -1.
REQ-017 SHALL keep a column counter 0..COLS-1; it increments, wrapping to 0, on each in_valid beat.
REQ-018 SHALL, on an in_valid beat, update only accumulators of the current column: acc += act for +1, acc -= act for -1, unchanged for 0.
REQ-019 SHALL sign-extend in_act to ACC_W and wrap accumulators modulo 2^ACC_W (no saturation).
REQ-020 SHALL implement FSM states ACCUM and DRAIN; accumulation proceeds in both states.
REQ-021 SHALL, on start_readout in ACCUM, copy all accumulators into the out queue (including any same-cycle in_valid beat), clear accumulators and the column counter, and enter DRAIN.
REQ-022 SHALL ignore start_readout in DRAIN.
REQ-023 SHALL assert out_valid the cycle after entering DRAIN, presenting queue entries in index order r*COLS+c, ascending.
REQ-024 SHALL hold out_data stable while out_valid && !out_ready and advance only on out_valid && out_ready.
REQ-025 SHALL return to ACCUM after the handshake of entry ROWS*COLS-1; out_valid is low the following cycle.
REQ-026 SHALL compute out_data as queue >>> out_shift, saturated to the signed OUT_W range.

Reset
REQ-027 SHALL, on reset (including mid-DRAIN), zero all accumulators, queue, column counter and index, enter ACCUM, and drive out_valid=0, out_data=0, busy=0 the next cycle.

Configuration
REQ-028 SHALL, with TERNARY_RELU_EN defined, output 0 for negative shifted values when the sampled relu is 1.
REQ-029 SHALL, without TERNARY_RELU_EN, keep the relu port but ignore it.

Structure
REQ-030 SHALL place the weight-encoding constants, the decode function and the FSM state enum in package ternary_mm_pkg.
REQ-031 SHALL use one sub-module, ternary_mac_cell: a single accumulator with column-enable, weight and clear inputs.

Verification
REQ-032 SHALL test: ROWS=4, COLS=2; beats (w=all +1, act=10),(w=all -1, act=3); readout shift 0 -> 8 outputs 10,-3 repeated per row.
REQ-033 SHALL test: 200 beats of act=127 with w=+1, then shift=4 -> entries saturate to 127; shift=8 -> 49 (col0 = 12700 >> 8).
REQ-034 SHALL test: start_readout together with in_valid (act=5, w=+1) -> beat appears in snapshot and the new tile starts at 0.
REQ-035 SHALL test: out_ready held low 3 cycles -> out_data stable; a second start_readout during DRAIN is ignored.
REQ-036 SHALL test: reset during the 3rd drain entry -> out_valid=0 next cycle and all accumulators read 0.
REQ-037 SHALL test: value -40 with relu=1 -> 0 when TERNARY_RELU_EN is defined, -40 when it is not.
